// File: rtl/pipe_commit_tracker.sv
// Refinement-check monitor: start/end bookkeeping, saturating cycle counter and
// per-pipe token tracking with commit/timeout. Define PIPE_COMMIT_TRACKER_CHECK_EN for the protocol checker.

module pipe_commit_lane #(
    parameter int NSTAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               valid_s1,
    input  logic [NSTAGES-1:0] stall,
    output logic [NSTAGES-1:0] stage_tok,
    output logic               commit
);
    logic [NSTAGES-1:1] tok_q;
    logic [NSTAGES-1:0] nxt;

    // Stage 1 has no register: the token exists only while start is high.
    assign stage_tok = {tok_q, start && valid_s1 && !stall[0]};
    assign nxt       = stage_tok & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_q  <= '0;
            commit <= 1'b0;
        end else begin
            for (int k = 1; k < NSTAGES; k++)
                if (!stall[k]) tok_q[k] <= nxt[k-1];
            commit <= nxt[NSTAGES-1];
        end
    end
endmodule

module pipe_commit_tracker #(
    parameter int NSTAGES    = 4,
    parameter int NPIPE      = 2,
    parameter int CNT_W      = 4,
    parameter int MAX_CYCLES = 6,
    parameter int END_CYCLE  = 1,
    parameter int END2_CYCLE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_i,
    input  logic [NPIPE-1:0]           valid_s1_i,
    input  logic [NPIPE*NSTAGES-1:0]   stall_i,
    output logic                       start_o,
    output logic                       started_o,
    output logic [CNT_W-1:0]           cycle_cnt_o,
    output logic                       edcond_o,
    output logic                       iend_o,
    output logic                       ended_o,
    output logic                       ended2_o,
    output logic [NPIPE*NSTAGES-1:0]   stage_tok_o,
    output logic [NPIPE-1:0]           commit_o,
    output logic                       commit_any_o,
    output logic                       timeout_o,
    output logic                       error_o
);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(END_CYCLE);
    localparam logic [CNT_W-1:0] CNT_END2 = CNT_W'(END2_CYCLE);

    typedef enum logic [1:0] {IDLE, START, STARTED} state_t;
    state_t state_q, state_d;

    logic commit_seen_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_o   = 1'b0;
        started_o = 1'b0;
        case (state_q)
            IDLE:    if (issue_i) state_d = START;
            START:   begin start_o = 1'b1; state_d = STARTED; end
            STARTED: started_o = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign edcond_o     = started_o && (cycle_cnt_o == CNT_END);
    assign iend_o       = edcond_o && !ended_o;
    assign commit_any_o = |commit_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_o   <= '0;
            ended_o       <= 1'b0;
            ended2_o      <= 1'b0;
            timeout_o     <= 1'b0;
            commit_seen_q <= 1'b0;
        end else begin
            if ((start_o || started_o) && cycle_cnt_o < CNT_MAX)
                cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (iend_o) ended_o <= 1'b1;
            if (ended_o && started_o && cycle_cnt_o == CNT_END2 && !ended2_o)
                ended2_o <= 1'b1;
            // A commit landing on the bound cycle still counts as in time.
            if (started_o && cycle_cnt_o == CNT_MAX && !commit_seen_q && !commit_any_o)
                timeout_o <= 1'b1;
            if (commit_any_o) commit_seen_q <= 1'b1;
        end
    end

    for (genvar p = 0; p < NPIPE; p++) begin : g_lane
        pipe_commit_lane #(.NSTAGES(NSTAGES)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .start     (start_o),
            .valid_s1  (valid_s1_i[p]),
            .stall     (stall_i[p*NSTAGES +: NSTAGES]),
            .stage_tok (stage_tok_o[p*NSTAGES +: NSTAGES]),
            .commit    (commit_o[p])
        );
    end

`ifdef PIPE_COMMIT_TRACKER_CHECK_EN
    logic [NPIPE-1:0][NSTAGES-1:0] tok_v, stl_v;
    logic [NPIPE-1:0]              committed_q;
    logic                          err_q, chk_hit;

    assign tok_v = stage_tok_o;
    assign stl_v = stall_i;

    // Loss: a stage releases its token into a neighbour that is holding.
    always_comb begin
        chk_hit = |(commit_o & committed_q);
        for (int p = 0; p < NPIPE; p++) begin
            if ((tok_v[p] & (tok_v[p] - NSTAGES'(1))) != '0) chk_hit = 1'b1;
            if (|(tok_v[p][NSTAGES-2:0] & ~stl_v[p][NSTAGES-2:0] & stl_v[p][NSTAGES-1:1]))
                chk_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            committed_q <= '0;
        end else begin
            if (chk_hit) err_q <= 1'b1;
            committed_q <= committed_q | commit_o;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_commit_tracker.sv
// Bench for pipe_commit_tracker: token-position model checked every cycle plus
// directed literal checks for each plan scenario.
module tb_pipe_commit_tracker;
    localparam int NS = 4, NP = 2, CW = 4, MAXC = 6, ENDC = 1, END2C = 2;

    logic clk = 1'b0, rst = 1'b1, issue = 1'b0;
    logic [NP-1:0] valid = '0;
    logic [NP*NS-1:0] stall = '0;
    logic start_o, started_o, edcond_o, iend_o, ended_o, ended2_o;
    logic commit_any_o, timeout_o, error_o;
    logic [CW-1:0] cnt_o;
    logic [NP*NS-1:0] tok_o;
    logic [NP-1:0] commit_o;

    int n_chk = 0, n_fail = 0;
    bit mon_en = 0;

    always #5 clk = ~clk;

    pipe_commit_tracker #(.NSTAGES(NS), .NPIPE(NP), .CNT_W(CW), .MAX_CYCLES(MAXC),
                          .END_CYCLE(ENDC), .END2_CYCLE(END2C)) dut (
        .clk(clk), .rst(rst), .issue_i(issue), .valid_s1_i(valid), .stall_i(stall),
        .start_o(start_o), .started_o(started_o), .cycle_cnt_o(cnt_o),
        .edcond_o(edcond_o), .iend_o(iend_o), .ended_o(ended_o), .ended2_o(ended2_o),
        .stage_tok_o(tok_o), .commit_o(commit_o), .commit_any_o(commit_any_o),
        .timeout_o(timeout_o), .error_o(error_o));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit st(int p, int k);
        return stall[p*NS + k - 1];
    endfunction

    // Model: phase, counter and an integer token position per pipe.
    int m_ph = 0, m_cnt = 0;
    int m_pos[NP];
    bit m_cp[NP];
    bit m_ended = 0, m_ended2 = 0, m_to = 0, m_seen = 0, m_err = 0;
    initial for (int p = 0; p < NP; p++) begin m_pos[p] = 0; m_cp[p] = 0; end

    always @(negedge clk) begin : model
        logic e_start, e_started, e_ed, e_iend, e_any, e_err;
        logic [NP*NS-1:0] e_tok;
        logic [NP-1:0] e_com;
        int k;
        bit cp;
        e_start = (m_ph == 1);
        e_started = (m_ph == 2);
        e_ed = e_started && (m_cnt == ENDC);
        e_iend = e_ed && !m_ended;
        e_tok = '0;
        e_com = '0;
        for (int p = 0; p < NP; p++) begin
            if (m_pos[p] != 0) e_tok[p*NS + m_pos[p] - 1] = 1'b1;
            if (e_start && valid[p] && !st(p, 1)) e_tok[p*NS] = 1'b1;
            e_com[p] = m_cp[p];
        end
        e_any = |e_com;
`ifdef PIPE_COMMIT_TRACKER_CHECK_EN
        e_err = m_err;
`else
        e_err = 1'b0;
`endif
        if (mon_en) begin
            chk("m_start", start_o, e_start);
            chk("m_started", started_o, e_started);
            chk("m_cnt", cnt_o, m_cnt);
            chk("m_edcond", edcond_o, e_ed);
            chk("m_iend", iend_o, e_iend);
            chk("m_ended", ended_o, m_ended);
            chk("m_ended2", ended2_o, m_ended2);
            chk("m_tok", tok_o, e_tok);
            chk("m_commit", commit_o, e_com);
            chk("m_any", commit_any_o, e_any);
            chk("m_timeout", timeout_o, m_to);
            chk("m_error", error_o, e_err);
        end
        if (rst) begin
            m_ph = 0; m_cnt = 0; m_ended = 0; m_ended2 = 0; m_to = 0; m_seen = 0; m_err = 0;
            for (int p = 0; p < NP; p++) begin m_pos[p] = 0; m_cp[p] = 0; end
        end else begin
            if (m_ended && e_started && m_cnt == END2C) m_ended2 = 1;
            if (e_iend) m_ended = 1;
            if (e_started && m_cnt == MAXC && !m_seen && !e_any) m_to = 1;
            if (e_any) m_seen = 1;
            for (int p = 0; p < NP; p++) begin
                cp = 0;
                k = m_pos[p];
                if (k != 0) begin
                    if (!st(p, k)) begin
                        if (k == NS) begin cp = 1; m_pos[p] = 0; end
                        else if (st(p, k + 1)) begin m_err = 1; m_pos[p] = 0; end
                        else m_pos[p] = k + 1;
                    end
                end else if (e_tok[p*NS]) begin
                    if (st(p, 2)) m_err = 1;
                    else m_pos[p] = 2;
                end
                m_cp[p] = cp;
            end
            if (m_ph != 0 && m_cnt < MAXC) m_cnt++;
            if (m_ph == 0 && issue) m_ph = 1;
            else if (m_ph == 1) m_ph = 2;
        end
    end

    // One reset cycle, then cycles 0..len-1 with per-test stimulus and literal checks.
    task automatic run_test(input int t, input int len);
        logic exp_err;
        rst = 1'b1; issue = 1'b0; valid = '0; stall = '0;
        @(posedge clk); #1;
        for (int c = 0; c < len; c++) begin
            rst = 1'b0; issue = 1'b0; stall = '0;
            case (t)
                1: begin valid = 2'b01; issue = (c == 0); end
                2: begin valid = 2'b01; issue = (c == 0); stall[2] = (c == 3 || c == 4); end
                3: begin valid = 2'b00; issue = (c == 0); end
                4: begin valid = 2'b11; issue = (c == 0); stall[NS+1] = (c == 2); end
                5: begin valid = 2'b01; issue = (c == 0 || c == 4); rst = (c == 3); end
                default: begin
                    valid = 2'b01; issue = (c == 0 || c == 5);
                    stall[1] = (c == 2); stall[2] = (c == 3);
                end
            endcase
            @(negedge clk);
            case (t)
                1: begin
                    if (c == 0) begin chk("t1_rst_start", start_o, 0); chk("t1_rst_cnt", cnt_o, 0); chk("t1_rst_tok", tok_o, 0); end
                    if (c == 1) begin chk("t1_start", start_o, 1); chk("t1_s1", tok_o, 8'h01); end
                    if (c == 2) begin chk("t1_started", started_o, 1); chk("t1_s2", tok_o, 8'h02); chk("t1_iend", iend_o, 1); end
                    if (c == 3) begin chk("t1_ended", ended_o, 1); chk("t1_s3", tok_o, 8'h04); end
                    if (c == 4) begin chk("t1_ended2", ended2_o, 1); chk("t1_s4", tok_o, 8'h08); end
                    if (c == 5) chk("t1_commit", commit_o, 2'b01);
                    if (c == 6) chk("t1_commit_off", commit_o, 2'b00);
                end
                2: begin
                    if (c == 5) chk("t2_hold_s3", tok_o, 8'h04);
                    if (c == 6) chk("t2_s4", tok_o, 8'h08);
                    if (c == 7) begin chk("t2_commit", commit_o, 2'b01); chk("t2_err", error_o, 0); end
                end
                3: begin
                    if (c == 7) chk("t3_cnt7", cnt_o, 6);
                    if (c == 8) begin chk("t3_cnt8", cnt_o, 6); chk("t3_to", timeout_o, 1); end
                    if (c == 11) chk("t3_to_sticky", timeout_o, 1);
                end
                4: begin
                    if (c == 5) begin chk("t4_c0", commit_o, 2'b01); chk("t4_any5", commit_any_o, 1); end
                    if (c == 6) begin chk("t4_c1", commit_o, 2'b10); chk("t4_any6", commit_any_o, 1); end
                    if (c == 9) chk("t4_no_to", timeout_o, 0);
                end
                5: begin
                    if (c == 4) begin chk("t5_rst_started", started_o, 0); chk("t5_rst_cnt", cnt_o, 0); chk("t5_rst_tok", tok_o, 0); end
                    if (c == 5) begin chk("t5_start", start_o, 1); chk("t5_cnt0", cnt_o, 0); end
                    if (c == 6) chk("t5_cnt1", cnt_o, 1);
                end
                default: begin
`ifdef PIPE_COMMIT_TRACKER_CHECK_EN
                    exp_err = 1'b1;
`else
                    exp_err = 1'b0;
`endif
                    if (c == 3) chk("t6_err3", error_o, 0);
                    if (c == 4) chk("t6_err4", error_o, exp_err);
                    if (c == 6) chk("t6_no_restart", start_o, 0);
                    if (c == 9) chk("t6_err_sticky", error_o, exp_err);
                end
            endcase
            @(posedge clk); #1;
        end
    endtask

    initial begin
        @(posedge clk); #1;
        mon_en = 1;
        run_test(1, 10);
        run_test(2, 10);
        run_test(3, 12);
        run_test(4, 10);
        run_test(5, 12);
        run_test(6, 12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_commit_tracker.md
Name: pipe_commit_tracker

Overview:
- Generic refinement-check monitor for multi-stage, stall-able pipelines in L2 ILA-vs-RTL verification wrappers.
- Generates the issue/start/end bookkeeping flags and a bounded cycle counter.
- Tracks one issued instruction token through NSTAGES stages on each of NPIPE independent pipelines, and reports per-pipe commit plus timeout.
- Instantiated inside per-instruction wrappers alongside the ILA model and the l2 DUT. It replaces hand-written per-stage monitor regs.

Parameters:
- NSTAGES, 4, stages per pipeline (>=2).
- NPIPE, 2, number of tracked pipelines (>=1).
- CNT_W, 4, cycle counter width.
- MAX_CYCLES, 6, counter saturation value and timeout bound (< 2**CNT_W).
- END_CYCLE, 1, counter value defining first end condition.
- END2_CYCLE, 2, counter value defining second end condition (> END_CYCLE).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_i  in  1  request to start tracking.
- valid_s1_i  in  NPIPE  per-pipe stage-1 valid.
- stall_i  in  NPIPE*NSTAGES  stall of stage k of pipe p at bit p*NSTAGES+k-1.
- start_o  out  1  one-cycle start pulse.
- started_o  out  1  sticky, set cycle after start_o.
- cycle_cnt_o  out  CNT_W  saturating cycle counter.
- edcond_o  out  1  first end condition.
- iend_o  out  1  first end event.
- ended_o  out  1  sticky first end.
- ended2_o  out  1  sticky second end.
- stage_tok_o  out  NPIPE*NSTAGES  token present in stage, same bit packing as stall_i.
- commit_o  out  NPIPE  one-cycle commit pulse per pipe.
- commit_any_o  out  1  OR of commit_o.
- timeout_o  out  1  sticky: bound reached with no commit.
- error_o  out  1  protocol checker flag (see Optional Feature).

Behaviour:
- Reset: all registered outputs and internal regs go to 0 on the clk edge with rst=1. Combinational outputs follow from the zeroed regs. A reset mid-operation aborts tracking fully; the next issue_i restarts cleanly.
- Start FSM:
  - IDLE: start_o=0, started_o=0. If issue_i is sampled high, go to START.
  - START: start_o=1 for exactly one cycle, then go to STARTED.
  - STARTED: started_o=1 until rst. Any issue_i while in START or STARTED is ignored.
- Counter:
  - Increments each cycle where (start_o|started_o) and cnt<MAX_CYCLES.
  - Saturates at MAX_CYCLES; never wraps.
- End flags:
  - edcond_o = started_o && cnt==END_CYCLE.
  - iend_o = edcond_o && !ended_o. ended_o <= 1 on iend_o.
  - ended2_o <= 1 when ended_o && started_o && cnt==END2_CYCLE && !ended2_o.
- Token tracking, per pipe p:
  - S1 token (combinational) = start_o && valid_s1_i[p] && !stall[p][1].
  - Stage k = 2..NSTAGES holds a register tok[k]. It loads next[k-1] when !stall[p][k] and holds otherwise.
  - next[k] = tok[k] && !stall[p][k].
  - commit_o[p] <= next[NSTAGES], unconditionally registered, so it is a one-cycle pulse.
  - stage_tok_o bit for stage 1 is the combinational S1 token; other bits are tok[k].
  - Latency with no stalls: commit_o one cycle after the token is in S_NSTAGES, i.e. NSTAGES cycles after start_o.
- Stalls:
  - A stalled stage holds its token.
  - If an upstream stage advances while the downstream stage is stalled, the token is overwritten. The checker flags this.
- Timeout:
  - commit_seen is set by commit_any_o.
  - timeout_o <= 1 when started_o && cnt==MAX_CYCLES && !commit_seen && !commit_any_o. Sticky.
  - A commit in the same cycle suppresses the timeout.

Optional Feature:
- Macro: PIPE_COMMIT_TRACKER_CHECK_EN.
- When defined, error_o is a sticky register set by any of:
  - more than one token bit set within one pipe;
  - a token lost by overwrite into a stalled stage;
  - commit_o asserted for a pipe that already committed since reset.
- When not defined, error_o is tied 0 and no checker logic is generated.

Test Plan:
1. NSTAGES=4, rst then issue_i=1 at cycle 0, valid_s1_i=01, no stalls -> start_o=1 @1, started_o @2, stage_tok S2 @2, S3 @3, S4 @4, commit_o=01 @5 (1 cycle), edcond_o/iend_o @2, ended_o @3, ended2_o @4.
2. As 1 with stall S3 of pipe0 high cycles 3-4 -> token stays in S3 cycles 3-5, S4 @6, commit_o[0] @7, error_o=0.
3. valid_s1_i=00 -> cnt reaches 6 @7 and holds at 6; no commit; timeout_o=1 @8 and stays 1.
4. valid_s1_i=11, pipe1 S2 stalled cycle 2 -> commit_o=01 @5, commit_o=10 @6, commit_any_o high both cycles, timeout_o=0.
5. rst=1 at cycle 3 mid-flight -> all outputs 0 @4; issue_i at cycle 4 -> start_o @5, cycle_cnt restarts from 0.
6. CHECK_EN defined, pipe0 S3 stalled while S2 advances cycle 3 -> error_o=1 @4 and sticky; issue_i re-pulsed at cycle 5 -> start_o stays 0.
